// File: rtl/srio_nwr_req_packer.sv
// Packs a user NWRITE stream into <=256-byte SRIO ireq packets, each led by a HELLO header beat.
// Optional NWR_TLAST_CHECK_EN builds a sticky user_tlast_in consistency check on err_o.
module srio_nwr_req_packer #(
   parameter logic [15:0] SRC_ID  = 16'h0001,
   parameter logic [15:0] DEST_ID = 16'h0002,
   parameter logic [1:0]  PRIO    = 2'd1
) (
   input  logic        log_clk,
   input  logic        log_rst,
   input  logic [33:0] user_addr_in,
   input  logic [3:0]  user_ftype_in,
   input  logic [3:0]  user_ttype_in,
   input  logic [11:0] user_tsize_in,
   input  logic [63:0] user_tdata_in,
   input  logic        user_tvalid_in,
   input  logic [7:0]  user_tkeep_in,
   input  logic        user_tlast_in,
   output logic        user_tready_o,
   output logic        nwr_ready_o,
   output logic        nwr_busy_o,
   output logic        nwr_done_o,
   output logic [63:0] ireq_tdata_o,
   output logic        ireq_tvalid_o,
   input  logic        ireq_tready_in,
   output logic [7:0]  ireq_tkeep_o,
   output logic        ireq_tlast_o,
   output logic [31:0] ireq_tuser_o,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

   state_t      state, state_nxt;
   logic [33:0] seg_addr;
   logic [3:0]  ftype, ttype;
   logic [12:0] remaining;
   logic [7:0]  tid;
   logic [5:0]  beat_cnt;
   logic [8:0]  seg_bytes, seg_round, seg_m1;
   logic [2:0]  last_n;
   logic        last_beat, data_hs, xfer_end;

   // Segment size is derived from the remaining count, which only moves on a segment's last beat
   assign seg_bytes = (remaining > 13'd256) ? 9'd256 : remaining[8:0];
   assign seg_round = seg_bytes + 9'd7;
   assign seg_m1    = seg_bytes - 9'd1;
   assign last_n    = seg_bytes[2:0];
   assign last_beat = (beat_cnt == 6'd1);
   assign data_hs   = (state == DATA) && user_tvalid_in && ireq_tready_in;
   assign xfer_end  = (remaining == {4'd0, seg_bytes});

   always_ff @(posedge log_clk) begin
      if (log_rst) begin
         state     <= IDLE;
         tid       <= 8'h00;
         seg_addr  <= '0;
         ftype     <= '0;
         ttype     <= '0;
         remaining <= '0;
         beat_cnt  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (user_tvalid_in) begin
               seg_addr  <= user_addr_in;
               ftype     <= user_ftype_in;
               ttype     <= user_ttype_in;
               remaining <= {1'b0, user_tsize_in} + 13'd1;
            end
            HDR: if (ireq_tready_in) begin
               tid      <= tid + 8'd1;
               beat_cnt <= seg_round[8:3];
            end
            DATA: if (data_hs) begin
               beat_cnt <= beat_cnt - 6'd1;
               if (last_beat) begin
                  remaining <= remaining - {4'd0, seg_bytes};
                  seg_addr  <= seg_addr + 34'd256;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt     = state;
      user_tready_o = 1'b0;
      nwr_ready_o   = 1'b0;
      nwr_busy_o    = 1'b1;
      nwr_done_o    = 1'b0;
      ireq_tdata_o  = '0;
      ireq_tvalid_o = 1'b0;
      ireq_tkeep_o  = '0;
      ireq_tlast_o  = 1'b0;
      ireq_tuser_o  = {SRC_ID, DEST_ID};
      case (state)
         IDLE: begin
            nwr_ready_o  = 1'b1;
            nwr_busy_o   = 1'b0;
            ireq_tuser_o = '0;
            if (user_tvalid_in) state_nxt = HDR;
         end
         HDR: begin
            ireq_tvalid_o = 1'b1;
            ireq_tkeep_o  = 8'hff;
            ireq_tdata_o  = {tid, ftype, ttype, 1'b0, PRIO, 1'b0, seg_m1[7:0], 2'b00, seg_addr};
            if (ireq_tready_in) state_nxt = DATA;
         end
         DATA: begin
            ireq_tvalid_o = user_tvalid_in;
            user_tready_o = ireq_tready_in;
            ireq_tdata_o  = user_tdata_in;
            ireq_tkeep_o  = 8'hff;
            if (last_beat) begin
               ireq_tlast_o = 1'b1;
               ireq_tkeep_o = (last_n == 3'd0) ? 8'hff : ~(8'hff >> last_n);
            end
            if (data_hs && last_beat) state_nxt = xfer_end ? DONE : HDR;
         end
         DONE: begin
            nwr_done_o = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef NWR_TLAST_CHECK_EN
   logic unused_ok;
   assign unused_ok = ^{user_tkeep_in, seg_round[2:0], seg_m1[8]};

   // user_tlast_in must mark exactly the final beat of the whole transfer
   always_ff @(posedge log_clk) begin
      if (log_rst)
         err_o <= 1'b0;
      else if (data_hs && (user_tlast_in != (last_beat && xfer_end)))
         err_o <= 1'b1;
   end
`else
   logic unused_ok;
   assign unused_ok = ^{user_tkeep_in, user_tlast_in, seg_round[2:0], seg_m1[8]};
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_srio_nwr_req_packer.sv
// Directed bench for srio_nwr_req_packer: segmentation, headers, stalls, tid wrap, reset abort, tlast check.
module tb_srio_nwr_req_packer;

   localparam logic [3:0] FT = 4'h5;
   localparam logic [3:0] TT = 4'h4;

   logic        log_clk = 1'b0;
   logic        log_rst = 1'b1;
   logic [33:0] user_addr_in = '0;
   logic [3:0]  user_ftype_in = FT;
   logic [3:0]  user_ttype_in = TT;
   logic [11:0] user_tsize_in = '0;
   logic [63:0] user_tdata_in = '0;
   logic        user_tvalid_in = 1'b0;
   logic [7:0]  user_tkeep_in = 8'h00;
   logic        user_tlast_in = 1'b0;
   logic        user_tready_o, nwr_ready_o, nwr_busy_o, nwr_done_o;
   logic [63:0] ireq_tdata_o;
   logic        ireq_tvalid_o;
   logic        ireq_tready_in = 1'b0;
   logic [7:0]  ireq_tkeep_o;
   logic        ireq_tlast_o;
   logic [31:0] ireq_tuser_o;
   logic        err_o;

   int          n_assert = 0;
   int          n_fail = 0;
   logic [7:0]  tid_m = 8'h00;
   logic        err_exp = 1'b0;

   srio_nwr_req_packer dut (
      .log_clk(log_clk), .log_rst(log_rst),
      .user_addr_in(user_addr_in), .user_ftype_in(user_ftype_in), .user_ttype_in(user_ttype_in),
      .user_tsize_in(user_tsize_in), .user_tdata_in(user_tdata_in), .user_tvalid_in(user_tvalid_in),
      .user_tkeep_in(user_tkeep_in), .user_tlast_in(user_tlast_in), .user_tready_o(user_tready_o),
      .nwr_ready_o(nwr_ready_o), .nwr_busy_o(nwr_busy_o), .nwr_done_o(nwr_done_o),
      .ireq_tdata_o(ireq_tdata_o), .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in),
      .ireq_tkeep_o(ireq_tkeep_o), .ireq_tlast_o(ireq_tlast_o), .ireq_tuser_o(ireq_tuser_o),
      .err_o(err_o)
   );

   always #5 log_clk = ~log_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Byte enables for a final beat carrying 'seg mod 8' bytes, first byte in the MSB lane
   function automatic logic [7:0] keep_of(input int seg);
      int nb;
      logic [7:0] k;
      nb = (seg % 8 == 0) ? 8 : seg % 8;
      k = '0;
      for (int i = 0; i < nb; i++) k[7-i] = 1'b1;
      return k;
   endfunction

   task automatic xfer(input logic [33:0] addr, input logic [11:0] tsize, input bit toggle,
                       input int tlast_beat, input int abort_at, input logic [31:0] tag);
      int total, rem, seg, left, sent, cyc;
      logic [33:0] sa;
      bit want_hdr, fin, stalled;
      logic [63:0] held;
      total = (int'(tsize) + 8) / 8;
      rem = int'(tsize) + 1;
      sa = addr;
      seg = 0; left = 0; sent = 0; cyc = 0;
      want_hdr = 1'b1; fin = 1'b0; stalled = 1'b0; held = '0;
      user_addr_in = addr;
      user_tsize_in = tsize;
      while (!fin && cyc < 4000) begin
         @(posedge log_clk); #1;
         cyc++;
         if (abort_at != 0 && sent == abort_at - 1) begin
            log_rst = 1'b1;
            user_tvalid_in = 1'b0;
            @(posedge log_clk); #1;
            log_rst = 1'b0;
            tid_m = 8'h00;
            err_exp = 1'b0;
            @(negedge log_clk);
            chk("rst_tvalid", 64'(ireq_tvalid_o), 64'd0);
            chk("rst_ready", 64'(nwr_ready_o), 64'd1);
            chk("rst_busy", 64'(nwr_busy_o), 64'd0);
            chk("rst_err", 64'(err_o), 64'd0);
            return;
         end
         ireq_tready_in = toggle ? ~ireq_tready_in : 1'b1;
         user_tvalid_in = (sent < total);
         user_tdata_in = {tag, 32'(sent + 1)};
         user_tlast_in = (sent + 1 == tlast_beat);
         @(negedge log_clk);
         if (stalled) begin
            chk("stall_valid", 64'(ireq_tvalid_o), 64'd1);
            chk("stall_data", ireq_tdata_o, held);
         end
         stalled = ireq_tvalid_o && !ireq_tready_in;
         held = ireq_tdata_o;
         if (ireq_tvalid_o && ireq_tready_in) begin
            if (want_hdr) begin
               seg = (rem > 256) ? 256 : rem;
               chk("hdr_data", ireq_tdata_o,
                   {tid_m, FT, TT, 1'b0, 2'd1, 1'b0, 8'(seg - 1), 2'b00, sa});
               chk("hdr_ctl", 64'({ireq_tkeep_o, ireq_tlast_o, user_tready_o, ireq_tuser_o}),
                   64'({8'hff, 1'b0, 1'b0, 32'h0001_0002}));
               tid_m = tid_m + 8'd1;
               left = (seg + 7) / 8;
               want_hdr = 1'b0;
            end else begin
               left--;
               chk("beat_data", ireq_tdata_o, {tag, 32'(sent + 1)});
               chk("beat_ctl", 64'({ireq_tkeep_o, ireq_tlast_o, user_tready_o}),
                   64'({(left == 0) ? keep_of(seg) : 8'hff, left == 0, 1'b1}));
               chk("err", 64'(err_o), 64'(err_exp));
`ifdef NWR_TLAST_CHECK_EN
               if (user_tlast_in != (sent + 1 == total)) err_exp = 1'b1;
`endif
               sent++;
               if (left == 0) begin
                  rem -= seg;
                  sa += 34'd256;
                  want_hdr = 1'b1;
                  if (rem == 0) fin = 1'b1;
               end
            end
         end
      end
      chk("xfer_complete", 64'(fin), 64'd1);
      @(posedge log_clk); #1;
      user_tvalid_in = 1'b0;
      user_tlast_in = 1'b0;
      @(negedge log_clk);
      chk("done_pulse", 64'({nwr_done_o, nwr_busy_o, nwr_ready_o}), 64'(3'b110));
      @(posedge log_clk); #1;
      @(negedge log_clk);
      chk("idle_after", 64'({nwr_done_o, nwr_busy_o, nwr_ready_o}), 64'(3'b001));
   endtask

   initial begin
      repeat (3) @(posedge log_clk);
      @(negedge log_clk);
      chk("reset_flags", 64'({nwr_ready_o, nwr_busy_o, nwr_done_o, user_tready_o, err_o}),
          64'(5'b10000));
      chk("reset_ireq", 64'({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o}), 64'd0);
      chk("reset_tdata", ireq_tdata_o, 64'd0);
      chk("reset_tuser", 64'(ireq_tuser_o), 64'd0);
      @(posedge log_clk); #1;
      log_rst = 1'b0;

      // single full packet, then a 1-byte trailing packet
      xfer(34'h1000, 12'd255, 1'b0, 32, 0, 32'h0000_0001);
      xfer(34'h2000, 12'd256, 1'b0, 33, 0, 32'h0000_0002);
      // backpressure on every other cycle, 3-byte trailing packet
      xfer(34'h3000, 12'd258, 1'b1, 33, 0, 32'h0000_0003);
      // tid wraps after 256 headers
      for (int k = 0; k < 257; k++)
         xfer(34'h4000 + 34'(k * 8), 12'd7, 1'b0, 1, 0, 32'h100 + 32'(k));
      // tlast on the first of two beats
      xfer(34'h8000, 12'd15, 1'b0, 1, 0, 32'h0000_0005);
      chk("err_sticky", 64'(err_o), 64'(err_exp));
      // reset on beat 10, then a clean transfer restarting at tid 0
      xfer(34'h9000, 12'd511, 1'b0, 64, 10, 32'h0000_0006);
      xfer(34'hA000, 12'd63, 1'b0, 8, 0, 32'h0000_0007);
      xfer(34'hB000, 12'd4095, 1'b0, 512, 0, 32'h0000_0008);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/srio_nwr_req_packer.md
Name: srio_nwr_req_packer

Overview:
- Sits directly downstream of the user NWRITE data generator and upstream of the SRIO Gen2 core initiator-request (ireq) AXI-Stream port.
- Latches the transfer descriptor (address, ftype, ttype, tsize) on the first data beat.
- Splits the transfer into packets of at most 256 bytes, prefixes each packet with a HELLO-format header beat, then forwards the payload.
- Drives the nwr_ready/busy/done handshake back to the generator.

Parameters:
- SRC_ID, 16'h0001, source device ID placed in ireq_tuser[31:16].
- DEST_ID, 16'h0002, destination device ID placed in ireq_tuser[15:0].
- PRIO, 2'd1, priority field of every header.

Ports:
- log_clk  in  1  logic clock
- log_rst  in  1  reset, synchronous, active-high
- user_addr_in  in  34  base byte address; 8-byte aligned
- user_ftype_in  in  4  FTYPE; sampled with descriptor
- user_ttype_in  in  4  TTYPE; sampled with descriptor
- user_tsize_in  in  12  total transfer bytes minus 1 (0..4095)
- user_tdata_in  in  64  payload qword
- user_tvalid_in  in  1  payload valid
- user_tkeep_in  in  8  ignored; keep is regenerated
- user_tlast_in  in  1  final payload beat of transfer
- user_tready_o  out  1  payload accepted when high with user_tvalid_in
- nwr_ready_o  out  1  idle, can accept a new transfer
- nwr_busy_o  out  1  transfer in progress
- nwr_done_o  out  1  one-cycle pulse, transfer complete
- ireq_tdata_o  out  64  header or payload
- ireq_tvalid_o  out  1  ireq valid
- ireq_tready_in  in  1  core ready
- ireq_tkeep_o  out  8  byte enables, MSB lane = first byte
- ireq_tlast_o  out  1  last beat of packet
- ireq_tuser_o  out  32  {SRC_ID, DEST_ID}
- err_o  out  1  sticky tlast-mismatch flag

Behaviour:
- Reset values:
  - nwr_ready_o=1; all other outputs 0.
  - State IDLE.
  - tid counter 8'h00.
  - Reset mid-transfer abandons the packet immediately; no tlast is generated.
- States:
  - IDLE:
    - user_tready_o=0, nwr_ready_o=1.
    - On user_tvalid_in=1: latch addr, ftype, ttype, and remaining = tsize+1 (13-bit).
    - seg_addr = addr; go HDR. The data beat is not consumed.
  - HDR:
    - ireq_tvalid_o=1, ireq_tlast_o=0, ireq_tkeep_o=8'hff, user_tready_o=0.
    - seg_bytes = min(256, remaining).
    - ireq_tdata_o = {tid[63:56], ftype[55:52], ttype[51:48], 1'b0, PRIO[46:45], 1'b0, (seg_bytes-1)[43:36], 2'b00, seg_addr[33:0]}.
    - On ireq_tready_in: tid+=1 (wraps 8'hff->8'h00); beat_cnt = ceil(seg_bytes/8); go DATA.
  - DATA (combinational pass-through):
    - ireq_tvalid_o = user_tvalid_in; user_tready_o = ireq_tready_in; ireq_tdata_o = user_tdata_in.
    - On each handshake: beat_cnt-=1.
    - When beat_cnt==1: ireq_tlast_o=1 and ireq_tkeep_o = ~(8'hff >> n), where n = seg_bytes mod 8 (n=0 means 8). Otherwise tkeep=8'hff.
    - Last-beat handshake: remaining-=seg_bytes; seg_addr+=256. If remaining==0 go DONE, else go HDR.
  - DONE: nwr_done_o=1 for one cycle; go IDLE.
- nwr_busy_o = (state != IDLE). nwr_ready_o = (state == IDLE).
- Header and ireq_tlast_o boundaries come only from the internal byte counters, never from user_tlast_in.
- Stall: tvalid and data hold while ireq_tready_in=0 in HDR. No combinational path from ireq_tready_in to ireq_tvalid_o.
- tsize=4095 gives exactly 16 packets; the last packet has size field 0xFF.

Optional Feature:
- Macro: NWR_TLAST_CHECK_EN
- Defined: err_o is set (sticky until log_rst) when either:
  - user_tlast_in=1 on an accepted beat that is not the final beat of the transfer, or
  - user_tlast_in=0 on the final beat.
  - Packing continues per the counters either way.
- Undefined: err_o is tied to 0 and no check logic is built.

Test Plan:
- tsize=255, addr=0x1000 -> one header (size 0xFF, addr 0x1000, tid 0x00); 32 payload beats; tlast on beat 32 with tkeep 8'hff; nwr_done_o pulse one cycle after.
- tsize=256, addr=0x2000 -> packet 1: size 0xFF, addr 0x2000, 32 beats. Packet 2: tid 0x01, size 0x00, addr 0x2100, 1 beat with tkeep 8'h80 and tlast.
- tsize=258 with ireq_tready_in toggling 1/0 every cycle -> header and payload hold during stalls; packet 2 has size 0x02 and tkeep 8'he0; no beats lost or duplicated (gen_data increments 1..33 seen in order).
- 257 back-to-back transfers of tsize=7 -> header tid wraps 0xFF->0x00; each transfer is 1 header + 1 beat with tkeep 8'hff.
- log_rst asserted on beat 10 of a tsize=511 transfer -> next cycle: ireq_tvalid_o=0, nwr_ready_o=1, tid=0x00; a fresh transfer then completes normally.
- With NWR_TLAST_CHECK_EN defined, tsize=15 and user_tlast_in on beat 1 -> err_o=1 from the next cycle; 2 beats are still forwarded with tlast on beat 2.
